// File: rtl/ledpanel_pkg.sv
// Shared LED-panel geometry, byte-lane encodings and writer FSM states.
// Used by the frame-buffer writer and the panel scan driver.
// Optional build macro: FB_DOUBLE_BUFFER_EN (adds a bank bit on top of the RAM address).
package ledpanel_pkg;

    localparam int PIXEL_DEPTH    = 8;
    localparam int PANEL_WIDTH    = 64;
    localparam int PANEL_HEIGHT   = 32;
    localparam int NUM_PANELS     = 1;
    localparam int IMG_WIDTH      = PANEL_WIDTH * NUM_PANELS;
    localparam int IMG_WIDTH_LOG2 = 6;
    localparam int HALF_ROWS      = PANEL_HEIGHT / 2;
    localparam int ROW_WIDTH      = $clog2(PANEL_HEIGHT);
    localparam int HALF_ROW_WIDTH = $clog2(HALF_ROWS);
    localparam int ADDR_WIDTH     = IMG_WIDTH_LOG2 + HALF_ROW_WIDTH;
    localparam int PIX_WIDTH      = 3 * PIXEL_DEPTH;
    localparam int DATA_WIDTH     = 6 * PIXEL_DEPTH;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int WR_ADDR_WIDTH  = ADDR_WIDTH + 1;
`else
    localparam int WR_ADDR_WIDTH  = ADDR_WIDTH;
`endif

    // Half-word enables: upper scan half lives in the upper half of the word.
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_NONE  = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fb_state_e;

    // Both halves carry the same pixel; the byte enables decide which lands.
    function automatic logic [DATA_WIDTH-1:0] replicate_pixel(input logic [PIX_WIDTH-1:0] pix);
        return {pix, pix};
    endfunction

endpackage

// File: rtl/fb_addr_map.sv
// Raster (row,col) to packed frame-buffer location: rows of the lower scan
// half fold onto the same addresses as the upper half and select the other
// half-word lane.
module fb_addr_map
    import ledpanel_pkg::*;
(
    input  logic [ROW_WIDTH-1:0]      row,
    input  logic [IMG_WIDTH_LOG2-1:0] col,
    output logic [ADDR_WIDTH-1:0]     addr,
    output logic [1:0]                be
);

    logic                      half_s;
    logic [HALF_ROW_WIDTH-1:0] row_in_half_s;

    // Fold the row onto its scan half and pick the half-word lane.
    always_comb begin
        half_s        = (row >= ROW_WIDTH'(HALF_ROWS));
        row_in_half_s = HALF_ROW_WIDTH'(row);
        be            = BE_UPPER;
        if (half_s) begin
            row_in_half_s = HALF_ROW_WIDTH'(row - ROW_WIDTH'(HALF_ROWS));
            be            = BE_LOWER;
        end else begin
            row_in_half_s = HALF_ROW_WIDTH'(row);
            be            = BE_UPPER;
        end
        addr = ADDR_WIDTH'(row_in_half_s) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(col);
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Frame-buffer writer: takes a raster pixel stream (valid/ready + start of
// frame) and issues registered writes into the dual-half packed RAM.
// Optional build macro: FB_DOUBLE_BUFFER_EN -- adds a bank bit as wr_addr MSB
// that flips after every completed frame, plus a disp_bank output.
module fb_pixel_writer
    import ledpanel_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic                     pix_sof,
    input  logic [PIX_WIDTH-1:0]     pix_data,
    output logic                     wr_en,
    output logic [1:0]               wr_be,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     frame_done,
`ifdef FB_DOUBLE_BUFFER_EN
    output logic                     disp_bank,
`endif
    output logic                     sof_err
);

    localparam logic [IMG_WIDTH_LOG2-1:0] LAST_COL = IMG_WIDTH_LOG2'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0]      LAST_ROW = ROW_WIDTH'(PANEL_HEIGHT - 1);

    fb_state_e                  state_r;
    fb_state_e                  next_state_s;
    logic [IMG_WIDTH_LOG2-1:0]  col_r;
    logic [IMG_WIDTH_LOG2-1:0]  col_next_s;
    logic [ROW_WIDTH-1:0]       row_r;
    logic [ROW_WIDTH-1:0]       row_next_s;
    logic [IMG_WIDTH_LOG2-1:0]  pix_col_s;
    logic [ROW_WIDTH-1:0]       pix_row_s;
    logic                       xfer_s;
    logic                       wr_now_s;
    logic                       sof_err_next_s;
    logic [ADDR_WIDTH-1:0]      map_addr_s;
    logic [1:0]                 map_be_s;
    logic [WR_ADDR_WIDTH-1:0]   full_addr_s;

    logic                       pix_ready_r;
    logic                       wr_en_r;
    logic [1:0]                 wr_be_r;
    logic [WR_ADDR_WIDTH-1:0]   wr_addr_r;
    logic [DATA_WIDTH-1:0]      wr_data_r;
    logic                       frame_done_r;
    logic                       sof_err_r;

    // pix_ready is registered, so it already reflects the current state.
    assign xfer_s = pix_valid & pix_ready_r;

    fb_addr_map u_addr_map (
        .row  (pix_row_s),
        .col  (pix_col_s),
        .addr (map_addr_s),
        .be   (map_be_s)
    );

`ifdef FB_DOUBLE_BUFFER_EN
    logic wr_bank_r;
    logic disp_bank_r;

    assign full_addr_s = {wr_bank_r, map_addr_s};
    assign disp_bank   = disp_bank_r;

    // Bank swap once per completed frame; the scan side always reads the other bank.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_bank_r   <= 1'b0;
            disp_bank_r <= 1'b1;
        end else if (state_r == DONE) begin
            wr_bank_r   <= ~wr_bank_r;
            disp_bank_r <= wr_bank_r;
        end else begin
            wr_bank_r   <= wr_bank_r;
            disp_bank_r <= disp_bank_r;
        end
    end
`else
    assign full_addr_s = map_addr_s;
`endif

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, raster counter update and the coordinate of the pixel being accepted.
    always_comb begin
        next_state_s   = state_r;
        col_next_s     = col_r;
        row_next_s     = row_r;
        pix_col_s      = col_r;
        pix_row_s      = row_r;
        wr_now_s       = 1'b0;
        sof_err_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                // Wait for a frame start; stray pixels are accepted and dropped.
                if (xfer_s && pix_sof) begin
                    wr_now_s     = 1'b1;
                    pix_col_s    = '0;
                    pix_row_s    = '0;
                    col_next_s   = IMG_WIDTH_LOG2'(1);
                    row_next_s   = '0;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (xfer_s) begin
                    wr_now_s = 1'b1;
                    if (pix_sof) begin
                        // Early frame start: truncate and restart at the origin.
                        sof_err_next_s = 1'b1;
                        pix_col_s      = '0;
                        pix_row_s      = '0;
                        col_next_s     = IMG_WIDTH_LOG2'(1);
                        row_next_s     = '0;
                    end else if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
                        col_next_s     = '0;
                        row_next_s     = '0;
                        next_state_s   = DONE;
                    end else if (col_r == LAST_COL) begin
                        col_next_s     = '0;
                        row_next_s     = row_r + ROW_WIDTH'(1);
                    end else begin
                        col_next_s     = col_r + IMG_WIDTH_LOG2'(1);
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                col_next_s   = '0;
                row_next_s   = '0;
            end
        endcase
    end

    // Raster position counters; held while the source stalls.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else begin
            col_r <= col_next_s;
            row_r <= row_next_s;
        end
    end

    // Registered write port and status pulses: one write per accepted pixel.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pix_ready_r  <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_be_r      <= BE_NONE;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            frame_done_r <= 1'b0;
            sof_err_r    <= 1'b0;
        end else begin
            pix_ready_r  <= (next_state_s != DONE);
            frame_done_r <= (next_state_s == DONE);
            sof_err_r    <= sof_err_next_s;
            wr_en_r      <= wr_now_s;
            if (wr_now_s) begin
                wr_be_r   <= map_be_s;
                wr_addr_r <= full_addr_s;
                wr_data_r <= replicate_pixel(pix_data);
            end else begin
                wr_be_r   <= BE_NONE;
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign pix_ready  = pix_ready_r;
    assign wr_en      = wr_en_r;
    assign wr_be      = wr_be_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign frame_done = frame_done_r;
    assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer (64x32 geometry). For a raster index i
// within one frame the expected RAM location is addr = i mod 1024 and
// be = 2'b10 for i < 1024 (rows 0..15), 2'b01 otherwise (rows 16..31).
module tb_fb_pixel_writer;
    import ledpanel_pkg::*;

    localparam int FRAME_PIX = 2048;

    logic                     clk_in = 1'b0;
    logic                     rst;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     pix_sof;
    logic [PIX_WIDTH-1:0]     pix_data;
    logic                     wr_en;
    logic [1:0]               wr_be;
    logic [WR_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     frame_done;
    logic                     sof_err;
`ifdef FB_DOUBLE_BUFFER_EN
    logic                     disp_bank;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fb_pixel_writer dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .wr_en      (wr_en),
        .wr_be      (wr_be),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
`ifdef FB_DOUBLE_BUFFER_EN
        .disp_bank  (disp_bank),
`endif
        .sof_err    (sof_err)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [PIX_WIDTH-1:0] pdat(input int idx);
        logic [31:0] v;
        v = idx;
        return {v[7:0], v[10:3] ^ 8'h5A, ~v[7:0]};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] exp_addr(input int idx);
        int r;
        r = idx % 1024;
        return ADDR_WIDTH'(r);
    endfunction

    function automatic logic [1:0] exp_be(input int idx);
        return (idx < 1024) ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int idx);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = pdat(idx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 0);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 3);
        step();
        step();
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        vectors++; if (wr_be !== 2'b00) begin miscompares++; $display("FAIL reset_wr_be: got %b want 00", wr_be); end
        vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pix_ready: got %0b want 0", pix_ready); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        vectors++; if (sof_err !== 1'b0) begin miscompares++; $display("FAIL reset_sof_err: got %0b want 0", sof_err); end
`ifdef FB_DOUBLE_BUFFER_EN
        vectors++; if (disp_bank !== 1'b1) begin miscompares++; $display("FAIL reset_disp_bank: got %0b want 1", disp_bank); end
`endif
        drive(1'b0, 1'b0, 0);
        rst = 1'b0;
        step();
        vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %0b want 1", pix_ready); end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < FRAME_PIX; i++) begin
            drive(1'b1, (i == 0), i);
            vectors++;
            if (pix_ready !== 1'b1) begin miscompares++; $display("FAIL ff_ready: pixel %0d got %0b want 1", i, pix_ready); end
            step();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== exp_addr(i) || wr_be !== exp_be(i) || wr_data !== {pdat(i), pdat(i)}) begin
                miscompares++;
                $display("FAIL ff_write: pixel %0d got en=%0b addr=%0d be=%b data=%h want en=1 addr=%0d be=%b data=%h",
                         i, wr_en, wr_addr, wr_be, wr_data, exp_addr(i), exp_be(i), {pdat(i), pdat(i)});
            end
            vectors++;
            if (frame_done !== (i == FRAME_PIX - 1)) begin miscompares++; $display("FAIL ff_frame_done: pixel %0d got %0b want %0b", i, frame_done, (i == FRAME_PIX - 1)); end
            if (i == 0) begin
                vectors++;
                if (wr_addr[ADDR_WIDTH-1:0] !== 10'd0 || wr_be !== 2'b10) begin miscompares++; $display("FAIL ff_pix_0_0: got addr=%0d be=%b want addr=0 be=10", wr_addr, wr_be); end
            end
            if (i == 1024) begin
                vectors++;
                if (wr_addr[ADDR_WIDTH-1:0] !== 10'd0 || wr_be !== 2'b01) begin miscompares++; $display("FAIL ff_pix_16_0: got addr=%0d be=%b want addr=0 be=01", wr_addr, wr_be); end
            end
            if (i == FRAME_PIX - 1) begin
                vectors++;
                if (wr_addr[ADDR_WIDTH-1:0] !== 10'd1023 || wr_be !== 2'b01) begin miscompares++; $display("FAIL ff_pix_31_63: got addr=%0d be=%b want addr=1023 be=01", wr_addr, wr_be); end
            end
        end
        vectors++;
        if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL ff_done_ready: got %0b want 0", pix_ready); end
        // Source keeps offering during DONE; nothing may be accepted.
        drive(1'b1, 1'b0, 9);
        step();
        vectors++;
        if (wr_en !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ff_after_done: got en=%0b done=%0b ready=%0b want 0 0 1", wr_en, frame_done, pix_ready);
        end
        drive(1'b0, 1'b0, 0);
    endtask

    task automatic test_idle_drop();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, k + 7);
            step();
            vectors++;
            if (wr_en !== 1'b0 || wr_be !== 2'b00) begin miscompares++; $display("FAIL idle_drop: transfer %0d got en=%0b be=%b want 0 00", k, wr_en, wr_be); end
        end
        drive(1'b1, 1'b1, 0);
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== 10'd0 || wr_be !== 2'b10 || wr_data !== {pdat(0), pdat(0)}) begin
            miscompares++;
            $display("FAIL idle_sof_write: got en=%0b addr=%0d be=%b want en=1 addr=0 be=10", wr_en, wr_addr, wr_be);
        end
        drive(1'b0, 1'b0, 0);
        step();
        vectors++;
        if (wr_en !== 1'b0 || wr_be !== 2'b00) begin miscompares++; $display("FAIL idle_stall: got en=%0b be=%b want 0 00", wr_en, wr_be); end
    endtask

    task automatic test_valid_gaps();
        int   i;
        int   cyc;
        logic v;
        do_reset();
        i   = 0;
        cyc = 0;
        while (i < FRAME_PIX && cyc < 20000) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                drive(1'b1, (i == 0), i);
                step();
                vectors++;
                if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== exp_addr(i) || wr_be !== exp_be(i) || wr_data !== {pdat(i), pdat(i)}) begin
                    miscompares++;
                    $display("FAIL gap_write: pixel %0d got en=%0b addr=%0d be=%b want en=1 addr=%0d be=%b", i, wr_en, wr_addr, wr_be, exp_addr(i), exp_be(i));
                end
                vectors++;
                if (frame_done !== (i == FRAME_PIX - 1)) begin miscompares++; $display("FAIL gap_frame_done: pixel %0d got %0b", i, frame_done); end
                i++;
            end else begin
                drive(1'b0, 1'b1, 77);
                step();
                vectors++;
                if (wr_en !== 1'b0 || wr_be !== 2'b00 || frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_idle_cycle: before pixel %0d got en=%0b be=%b done=%0b want 0 00 0", i, wr_en, wr_be, frame_done);
                end
            end
            cyc++;
        end
        vectors++;
        if (i != FRAME_PIX) begin miscompares++; $display("FAIL gap_timeout: got %0d pixels want %0d", i, FRAME_PIX); end
        drive(1'b0, 1'b0, 0);
        step();
    endtask

    task automatic test_sof_restart();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, (i == 0), i);
            step();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== exp_addr(i) || sof_err !== 1'b0) begin
                miscompares++;
                $display("FAIL sof_pre: pixel %0d got en=%0b addr=%0d err=%0b want en=1 addr=%0d err=0", i, wr_en, wr_addr, sof_err, exp_addr(i));
            end
        end
        drive(1'b1, 1'b1, 500);
        step();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== 10'd0 || wr_be !== 2'b10 || wr_data !== {pdat(500), pdat(500)}) begin
            miscompares++;
            $display("FAIL sof_restart_write: got en=%0b addr=%0d be=%b want en=1 addr=0 be=10", wr_en, wr_addr, wr_be);
        end
        vectors++;
        if (sof_err !== 1'b1) begin miscompares++; $display("FAIL sof_err_pulse: got %0b want 1", sof_err); end
        for (int i = 1; i < FRAME_PIX; i++) begin
            drive(1'b1, 1'b0, i);
            step();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== exp_addr(i) || wr_be !== exp_be(i) || sof_err !== 1'b0) begin
                miscompares++;
                $display("FAIL sof_post: pixel %0d got en=%0b addr=%0d be=%b err=%0b want en=1 addr=%0d be=%b err=0",
                         i, wr_en, wr_addr, wr_be, sof_err, exp_addr(i), exp_be(i));
            end
            vectors++;
            if (frame_done !== (i == FRAME_PIX - 1)) begin miscompares++; $display("FAIL sof_frame_done: pixel %0d got %0b", i, frame_done); end
        end
        drive(1'b0, 1'b0, 0);
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i <= 300; i++) begin
            drive(1'b1, (i == 0), i);
            step();
        end
        vectors++;
        if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== 10'd300 || wr_be !== 2'b10) begin
            miscompares++;
            $display("FAIL arst_pre: got en=%0b addr=%0d be=%b want en=1 addr=300 be=10", wr_en, wr_addr, wr_be);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (wr_en !== 1'b0 || wr_be !== 2'b00 || wr_addr !== '0 || wr_data !== '0) begin
            miscompares++;
            $display("FAIL arst_write_port: got en=%0b be=%b addr=%0d data=%h want all 0", wr_en, wr_be, wr_addr, wr_data);
        end
        vectors++;
        if (pix_ready !== 1'b0 || frame_done !== 1'b0 || sof_err !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_status: got ready=%0b done=%0b err=%0b want 0 0 0", pix_ready, frame_done, sof_err);
        end
        drive(1'b0, 1'b0, 0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), i);
            step();
            vectors++;
            if (wr_en !== 1'b1 || wr_addr[ADDR_WIDTH-1:0] !== ADDR_WIDTH'(i) || wr_be !== 2'b10 || wr_data !== {pdat(i), pdat(i)}) begin
                miscompares++;
                $display("FAIL arst_new_frame: pixel %0d got en=%0b addr=%0d be=%b want en=1 addr=%0d be=10", i, wr_en, wr_addr, wr_be, i);
            end
        end
        drive(1'b0, 1'b0, 0);
        step();
    endtask

`ifdef FB_DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        logic bank;
        do_reset();
        bank = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FRAME_PIX; i++) begin
                drive(1'b1, (i == 0), i);
                step();
                if (i == 0) begin
                    vectors++;
                    if (wr_addr[ADDR_WIDTH] !== bank || disp_bank !== ~bank) begin
                        miscompares++;
                        $display("FAIL db_bank: frame %0d got msb=%0b disp=%0b want msb=%0b disp=%0b", f, wr_addr[ADDR_WIDTH], disp_bank, bank, ~bank);
                    end
                end
            end
            vectors++;
            if (frame_done !== 1'b1) begin miscompares++; $display("FAIL db_frame_done: frame %0d got %0b want 1", f, frame_done); end
            drive(1'b0, 1'b0, 0);
            step();
            bank = ~bank;
            vectors++;
            if (disp_bank !== ~bank) begin miscompares++; $display("FAIL db_swap: frame %0d got disp=%0b want %0b", f, disp_bank, ~bank); end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 0);
        test_reset();
        test_full_frame();
        test_idle_drop();
        test_valid_gaps();
        test_sof_restart();
        test_async_reset();
`ifdef FB_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
